// File: rtl/traffic_light_controller.sv
// Two-road traffic-light sequencer: Moore FSM over four phases with a per-phase
// second counter; main-road congestion may extend main GO and cut side GO short.
module traffic_light_controller #(
    parameter int MAIN_GO      = 40,
    parameter int MAIN_GO_EXT  = 60,
    parameter int SIDE_GO      = 20,
    parameter int SIDE_GO_CONG = 10,
    parameter int ATT          = 5,
    parameter int CNT_W        = 7
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cong,
    output logic [1:0] main_state,
    output logic [1:0] side_state
);

    localparam logic [1:0] LAMP_STOP     = 2'b00;
    localparam logic [1:0] LAMP_STOP_ATT = 2'b01;
    localparam logic [1:0] LAMP_GO       = 2'b10;
    localparam logic [1:0] LAMP_GO_ATT   = 2'b11;

    localparam logic [CNT_W-1:0] MAIN_LAST     = CNT_W'(MAIN_GO - 1);
    localparam logic [CNT_W-1:0] MAIN_EXT_LAST = CNT_W'(MAIN_GO_EXT - 1);
    localparam logic [CNT_W-1:0] SIDE_LAST     = CNT_W'(SIDE_GO - 1);
    localparam logic [CNT_W-1:0] SIDE_CUT_MIN  = CNT_W'(SIDE_GO_CONG - 1);
    localparam logic [CNT_W-1:0] ATT_LAST      = CNT_W'(ATT - 1);

    typedef enum logic [1:0] {
        S0 = 2'd0,  // main GO, side STOP
        S1 = 2'd1,  // main GO_ATT, side STOP_ATT
        S2 = 2'd2,  // main STOP, side GO
        S3 = 2'd3   // main STOP_ATT, side GO_ATT
    } phase_t;

    phase_t           phase_reg, phase_next;
    logic [CNT_W-1:0] cnt_reg, cnt_next;
    logic             ext_reg, ext_next;
    logic             leave;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase_reg <= S0;
            cnt_reg   <= '0;
            ext_reg   <= 1'b0;
        end else begin
            phase_reg <= phase_next;
            cnt_reg   <= cnt_next;
            ext_reg   <= ext_next;
        end
    end

    always_comb begin
        phase_next = phase_reg;
        ext_next   = ext_reg;
        leave      = 1'b0;
        case (phase_reg)
            S0: begin
                // Congestion only matters on the last base second; once extended it is latched.
                if (ext_reg) begin
                    leave = (cnt_reg == MAIN_EXT_LAST);
                end else if (cnt_reg == MAIN_LAST) begin
                    if (cong) ext_next = 1'b1;
                    else      leave    = 1'b1;
                end
                if (leave) phase_next = S1;
            end
            S1: begin
                leave = (cnt_reg == ATT_LAST);
                if (leave) phase_next = S2;
            end
            S2: begin
                leave = (cnt_reg == SIDE_LAST) || (cong && (cnt_reg >= SIDE_CUT_MIN));
                if (leave) phase_next = S3;
            end
            S3: begin
                leave = (cnt_reg == ATT_LAST);
                if (leave) phase_next = S0;
            end
            default: begin
                leave      = 1'b1;
                phase_next = S0;
            end
        endcase
        if (leave) ext_next = 1'b0;
        cnt_next = leave ? '0 : cnt_reg + 1'b1;
    end

    always_comb begin
        main_state = LAMP_GO;
        side_state = LAMP_STOP;
        case (phase_reg)
            S0: begin main_state = LAMP_GO;       side_state = LAMP_STOP;     end
            S1: begin main_state = LAMP_GO_ATT;   side_state = LAMP_STOP_ATT; end
            S2: begin main_state = LAMP_STOP;     side_state = LAMP_GO;       end
            S3: begin main_state = LAMP_STOP_ATT; side_state = LAMP_GO_ATT;   end
            default: begin main_state = LAMP_GO;  side_state = LAMP_STOP;     end
        endcase
    end

endmodule

// File: tb/tb_traffic_light_controller.sv
// Bench for traffic_light_controller: scenario-driven and random congestion,
// checked every cycle against a phase/elapsed-seconds model and by literal phase lengths.
module tb_traffic_light_controller;

    localparam int MAIN_GO = 40, MAIN_GO_EXT = 60, SIDE_GO = 20, SIDE_GO_CONG = 10, ATT = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       cong = 1'b0;
    logic [1:0] main_state, side_state;

    traffic_light_controller dut (
        .clk(clk), .rst_n(rst_n), .cong(cong),
        .main_state(main_state), .side_state(side_state)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int mode  = 0;

    // Lamp pairs per phase, indexed by phase number in cyclic order.
    logic [1:0] lamp_main [4] = '{2'b10, 2'b11, 2'b00, 2'b01};
    logic [1:0] lamp_side [4] = '{2'b00, 2'b01, 2'b10, 2'b11};

    int m_phase = 0;  // model phase 0..3
    int m_cnt   = 0;  // whole seconds already spent in the phase
    bit m_ext   = 0;

    task automatic check(input string nm, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", nm, got, exp, $time);
        end
    endtask

    // Model: a phase ends once its elapsed seconds reach the duration the rules allow.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_phase <= 0; m_cnt <= 0; m_ext <= 0;
        end else begin
            int  el;
            bit  done;
            el   = m_cnt + 1;
            done = 0;
            case (m_phase)
                0: begin
                    if (m_ext) done = (el == MAIN_GO_EXT);
                    else if (el == MAIN_GO) begin
                        if (cong) m_ext <= 1;
                        else      done = 1;
                    end
                end
                2: done = (el == SIDE_GO) || (cong && el >= SIDE_GO_CONG);
                default: done = (el == ATT);
            endcase
            if (done) begin
                m_phase <= (m_phase + 1) % 4;
                m_cnt   <= 0;
                m_ext   <= 0;
            end else begin
                m_cnt <= el;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        check("main_lamp", int'(main_state), int'(lamp_main[m_phase]));
        check("side_lamp", int'(side_state), int'(lamp_side[m_phase]));
        if (main_state[1] && side_state[1]) check("both_active", 1, 0);
    end

    function automatic logic drive(input int md);
        case (md)
            0: return 1'b0;
            1: return (m_phase == 0) && (m_cnt == 39);
            2: return (m_phase == 0) && ((m_cnt >= 20 && m_cnt <= 24) || m_cnt == 38);
            3: return (m_phase == 2);
            4: return (m_phase == 2) && (m_cnt >= 15);
            5: return (m_phase == 1) || (m_phase == 3);
            6: return 1'b1;
            default: return 1'($urandom_range(0, 1));
        endcase
    endfunction

    task automatic cycle();
        @(negedge clk);
        #1;
        cong = drive(mode);
    endtask

    task automatic set_mode(input int md);
        mode = md;
        cong = drive(mode);
    endtask

    // Length in seconds of the next run of main lamp mm, checked against a literal.
    task automatic expect_len(input logic [1:0] mm, input int len, input string nm);
        int n = 0;
        int guard = 0;
        while (main_state != mm && guard < 200) begin cycle(); guard++; end
        while (main_state == mm && n < 200) begin cycle(); n++; end
        $display("phase %s main=%b length=%0d expected=%0d", nm, mm, n, len);
        check(nm, n, len);
    endtask

    initial begin
        set_mode(0);
        rst_n = 1'b0;
        #1;
        check("reset_main", int'(main_state), 2);
        check("reset_side", int'(side_state), 0);
        repeat (3) cycle();
        rst_n = 1'b1;

        expect_len(2'b10, 40, "base_s0");
        expect_len(2'b11, 5,  "base_s1");
        expect_len(2'b00, 20, "base_s2");
        expect_len(2'b01, 5,  "base_s3");
        expect_len(2'b10, 40, "base_s0_again");

        set_mode(1);
        expect_len(2'b11, 5,  "pre_ext_s1");
        expect_len(2'b00, 20, "pre_ext_s2");
        expect_len(2'b01, 5,  "pre_ext_s3");
        expect_len(2'b10, 60, "ext_s0");

        set_mode(2);
        expect_len(2'b11, 5,  "s1_after_ext");
        expect_len(2'b00, 20, "s2_mode2");
        expect_len(2'b01, 5,  "s3_mode2");
        expect_len(2'b10, 40, "noext_s0");

        set_mode(3);
        expect_len(2'b11, 5,  "s1_mode3");
        expect_len(2'b00, 10, "side_cut_10");
        expect_len(2'b01, 5,  "s3_mode3");

        set_mode(4);
        expect_len(2'b10, 40, "s0_mode4");
        expect_len(2'b11, 5,  "s1_mode4");
        expect_len(2'b00, 16, "side_cut_16");
        expect_len(2'b01, 5,  "s3_mode4");

        set_mode(5);
        expect_len(2'b10, 40, "s0_att_cong");
        expect_len(2'b11, 5,  "s1_att_cong");
        expect_len(2'b00, 20, "s2_att_cong");
        expect_len(2'b01, 5,  "s3_att_cong");

        set_mode(6);
        for (int r = 0; r < 4; r++) begin
            expect_len(2'b10, 60, "steady_s0");
            expect_len(2'b11, 5,  "steady_s1");
            expect_len(2'b00, 10, "steady_s2");
            expect_len(2'b01, 5,  "steady_s3");
        end

        set_mode(0);
        begin
            int g = 0;
            while (!(m_phase == 2 && m_cnt == 7) && g < 200) begin cycle(); g++; end
            check("reach_s2_cnt7", int'(g < 200), 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        $display("async reset mid-S2: main=%b side=%b", main_state, side_state);
        check("async_rst_main", int'(main_state), 2);
        check("async_rst_side", int'(side_state), 0);
        cycle();
        rst_n = 1'b1;
        expect_len(2'b10, 40, "post_rst_s0");
        expect_len(2'b11, 5,  "post_rst_s1");

        set_mode(7);
        repeat (2000) cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
